// File: rtl/bcd_counter_00_99_ctrl.sv
// Two-digit BCD 00-99 up/down counter with start/pause, clear and direction buttons.
// Optional macro BTN_DEBOUNCE_EN builds a counter-based debounce filter per button.

module bcd_btn_cond #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic sync1, sync2, lvl, lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    logic [CW-1:0] cnt;

    // Level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (sync2 == lvl) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            lvl <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign lvl = sync2;
    // DB_CYCLES has no effect without the filter; this block only names that fact.
    if (DB_CYCLES < 1) begin : g_db_cycles_ignored
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= 1'b0;
            press <= 1'b0;
        end else begin
            lvl_q <= lvl;
            press <= lvl & ~lvl_q;
        end
    end
endmodule

module bcd_counter_00_99_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       btn_dir,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       dir_down,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state;
    logic [PW-1:0] psc;
    logic [2:0]    raw, press;
    logic          start_p, clr_p, dir_p;
    logic [3:0]    tens_nx, ones_nx;
    logic          wrap_nx;

    assign raw = {btn_dir, btn_clr, btn_start};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        bcd_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    assign start_p = press[0];
    assign clr_p   = press[1];
    assign dir_p   = press[2];

    // Next digits for one count step in the current (pre-toggle) direction.
    always_comb begin
        tens_nx = tens;
        ones_nx = ones;
        wrap_nx = 1'b0;
        if (!dir_down) begin
            if (ones < 4'd9) begin
                ones_nx = ones + 4'd1;
            end else begin
                ones_nx = 4'd0;
                if (tens < 4'd9) begin
                    tens_nx = tens + 4'd1;
                end else begin
                    tens_nx = 4'd0;
                    wrap_nx = 1'b1;
                end
            end
        end else begin
            if (ones > 4'd0) begin
                ones_nx = ones - 4'd1;
            end else begin
                ones_nx = 4'd9;
                if (tens > 4'd0) begin
                    tens_nx = tens - 4'd1;
                end else begin
                    tens_nx = 4'd9;
                    wrap_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            psc      <= '0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            running  <= 1'b0;
            dir_down <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (dir_p)
                dir_down <= ~dir_down;
            if (clr_p) begin
                state   <= IDLE;
                psc     <= '0;
                tens    <= 4'd0;
                ones    <= 4'd0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                        psc     <= '0;
                    end
                    RUN: if (start_p) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (psc == PW'(TICK_DIV - 1)) begin
                        psc  <= '0;
                        tens <= tens_nx;
                        ones <= ones_nx;
                        wrap <= wrap_nx;
                    end else begin
                        psc <= psc + PW'(1);
                    end
                    PAUSE: if (start_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bcd_counter_00_99_ctrl.sv
// Directed bench for bcd_counter_00_99_ctrl with TICK_DIV=10, DB_CYCLES=4.
// Snapshot layout: {tens[3:0], ones[3:0], running, dir_down, wrap}.

module tb_bcd_counter_00_99_ctrl;
    localparam int TICK = 10;
    localparam int DB   = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int LAT     = DB + 3;
    localparam int BOUNCES = 1;
`else
    localparam int LAT     = 3;
    localparam int BOUNCES = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_clr = 1'b0, btn_dir = 1'b0;
    logic [3:0] tens, ones;
    logic       running, dir_down, wrap;
    wire [10:0] snap = {tens, ones, running, dir_down, wrap};

    int vecs = 0;
    int errs = 0;
    int run_changes = 0;
    logic run_q = 1'b0;

    bcd_counter_00_99_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .btn_dir   (btn_dir),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .dir_down  (dir_down),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (running !== run_q) run_changes++;
        run_q = running;
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Holds the chosen buttons until the edge their effect lands on, then releases.
    task automatic press(input logic s, input logic c, input logic d);
        btn_start = s; btn_clr = c; btn_dir = d;
        adv(LAT + 1);
        btn_start = 1'b0; btn_clr = 1'b0; btn_dir = 1'b0;
    endtask

    task automatic test_reset;
        logic [10:0] exp;
        exp = 11'd0;
        rst = 1'b1;
        adv(5);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL reset_held: got %h want %h", snap, exp); end
        rst = 1'b0;
        adv(1);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL reset_release: got %h want %h", snap, exp); end
        adv(100);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL idle_100: got %h want %h", snap, exp); end
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        pat = 5'b10101;
        run_changes = 0;
        for (int i = 4; i >= 0; i--) begin
            btn_start = pat[i];
            adv(1);
        end
        btn_start = 1'b1;
        adv(10);
        btn_start = 1'b0;
        adv(LAT + 2);
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL bounce_running: got %b want 1", running); end
        vecs++; if (run_changes != BOUNCES) begin errs++; $display("FAIL bounce_toggles: got %0d want %0d", run_changes, BOUNCES); end
    endtask

    task automatic test_run_wrap;
        logic [10:0] exp;
        press(1'b0, 1'b1, 1'b0);
        exp = {4'd0, 4'd0, 3'b000};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL clr_idle: got %h want %h", snap, exp); end
        btn_start = 1'b1;
        adv(LAT);
        vecs++; if (running !== 1'b0) begin errs++; $display("FAIL start_early: got %b want 0", running); end
        adv(1);
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL start_latency: got %b want 1", running); end
        adv(TICK - 1);
        exp = {4'd0, 4'd0, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL first_step_early: got %h want %h", snap, exp); end
        adv(1);
        exp = {4'd0, 4'd1, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL first_step: got %h want %h", snap, exp); end
        adv(2);
        btn_start = 1'b0;
        adv(978);
        exp = {4'd9, 4'd9, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_99: got %h want %h", snap, exp); end
        adv(9);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_99_hold: got %h want %h", snap, exp); end
        adv(1);
        exp = {4'd0, 4'd0, 3'b101};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_wrap: got %h want %h", snap, exp); end
        adv(1);
        exp = {4'd0, 4'd0, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_wrap_pulse: got %h want %h", snap, exp); end
    endtask

    task automatic test_dir;
        logic [10:0] exp;
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        exp = {4'd0, 4'd0, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL dir_start: got %h want %h", snap, exp); end
        adv(50);
        exp = {4'd0, 4'd5, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL dir_at05: got %h want %h", snap, exp); end
        press(1'b0, 1'b0, 1'b1);
        exp = {4'd0, 4'd5, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL dir_toggle: got %h want %h", snap, exp); end
        adv(TICK - 1 - LAT);
        exp = {4'd0, 4'd4, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_04: got %h want %h", snap, exp); end
        adv(TICK);
        exp = {4'd0, 4'd3, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_03: got %h want %h", snap, exp); end
        adv(3 * TICK);
        exp = {4'd0, 4'd0, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_00: got %h want %h", snap, exp); end
        adv(TICK);
        exp = {4'd9, 4'd9, 3'b111};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_wrap: got %h want %h", snap, exp); end
        adv(1);
        exp = {4'd9, 4'd9, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_wrap_pulse: got %h want %h", snap, exp); end
    endtask

    task automatic test_pause;
        logic [10:0] exp;
        press(1'b0, 1'b1, 1'b0);
        exp = {4'd0, 4'd0, 3'b010};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL clr_keeps_dir: got %h want %h", snap, exp); end
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        adv(370);
        exp = {4'd3, 4'd7, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_37: got %h want %h", snap, exp); end
        press(1'b1, 1'b0, 1'b0);
        exp = {4'd3, 4'd7, 3'b000};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL pause_enter: got %h want %h", snap, exp); end
        adv(50);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL pause_hold: got %h want %h", snap, exp); end
        press(1'b1, 1'b0, 1'b0);
        exp = {4'd3, 4'd7, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL resume: got %h want %h", snap, exp); end
        // Paused with prescaler at LAT, so the step lands TICK-LAT edges after resume.
        adv(TICK - 1 - LAT);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL resume_early: got %h want %h", snap, exp); end
        adv(1);
        exp = {4'd3, 4'd8, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL resume_step: got %h want %h", snap, exp); end
    endtask

    task automatic test_clr_start;
        logic [10:0] exp;
        adv(4 * TICK);
        exp = {4'd4, 4'd2, 3'b100};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL up_42: got %h want %h", snap, exp); end
        press(1'b1, 1'b1, 1'b0);
        exp = {4'd0, 4'd0, 3'b000};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL clr_wins: got %h want %h", snap, exp); end
        adv(LAT + 3);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL clr_wins_hold: got %h want %h", snap, exp); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] exp;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        exp = {4'd0, 4'd0, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_start: got %h want %h", snap, exp); end
        adv(TICK);
        exp = {4'd9, 4'd9, 3'b111};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_first_wrap: got %h want %h", snap, exp); end
        adv(36 * TICK);
        exp = {4'd6, 4'd3, 3'b110};
        vecs++; if (snap !== exp) begin errs++; $display("FAIL down_63: got %h want %h", snap, exp); end
        rst = 1'b1;
        #1;
        exp = 11'd0;
        vecs++; if (snap !== exp) begin errs++; $display("FAIL async_reset: got %h want %h", snap, exp); end
        adv(3);
        rst = 1'b0;
        adv(2 * TICK);
        vecs++; if (snap !== exp) begin errs++; $display("FAIL post_reset_idle: got %h want %h", snap, exp); end
    endtask

    initial begin
        test_reset;
        test_bounce;
        test_run_wrap;
        test_dir;
        test_pause;
        test_clr_start;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
